// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder FSM and its word array.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam int BURST_BEATS = 4;
  localparam int BEAT_W      = $clog2(BURST_BEATS);

endpackage

// File: rtl/mem_resp_array.sv
// Single-port word RAM: synchronous write, registered read (read-before-write).
module mem_resp_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency load/store responder, one request outstanding at a time.
// Define MEMRESP_BURST_EN to add the req_burst port and 4-beat line-fill reads.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEMRESP_BURST_EN
  input  logic              req_burst,
`endif
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_last,
  output logic              busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_wr;
  logic                  r_resp_valid;
  logic                  r_last;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_wdata;

  logic                  w_accept;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_arr_addr;
  logic [DATA_W-1:0]     w_q;
  logic                  w_unused;

  assign req_ready = (r_state == S_IDLE) & ~rst;
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_unused  = &{1'b0, req_addr[0], req_addr[ADDR_W-1:DEPTH_LOG2+1]};

  // The store commits on the same edge that enters DATA, so a reset before then drops it.
  assign w_we = (r_state == S_WAIT) && (r_cnt == '0) && r_wr;

`ifdef MEMRESP_BURST_EN
  logic              r_burst;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_rd_beat;

  // Array is read one cycle ahead of each beat: beat 0 while leaving WAIT, beat n+1 during beat n.
  assign w_rd_beat  = (r_state == S_DATA) ? r_beat + BEAT_W'(1) : '0;
  assign w_arr_addr = r_burst ? {r_idx[DEPTH_LOG2-1:BEAT_W], w_rd_beat} : r_idx;
`else
  assign w_arr_addr = r_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wr         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_last       <= 1'b0;
`ifdef MEMRESP_BURST_EN
      r_burst      <= 1'b0;
      r_beat       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_wr    <= req_wr;
`ifdef MEMRESP_BURST_EN
            r_burst <= req_burst & ~req_wr;
            r_beat  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= S_DATA;
            r_resp_valid <= 1'b1;
`ifdef MEMRESP_BURST_EN
            r_beat       <= '0;
            r_last       <= ~r_burst;
`else
            r_last       <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DATA: begin
`ifdef MEMRESP_BURST_EN
          if (r_last) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_last       <= 1'b0;
          end else begin
            r_beat <= r_beat + BEAT_W'(1);
            r_last <= (r_beat == BEAT_W'(BURST_BEATS - 2));
          end
`else
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_last       <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= req_addr[DEPTH_LOG2:1];
      r_wdata <= req_wdata;
    end
  end

  mem_resp_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_addr (w_arr_addr),
    .i_wdata(r_wdata),
    .o_rdata(w_q)
  );

  assign resp_valid = r_resp_valid;
  assign resp_last  = r_last;
  assign resp_rdata = (r_resp_valid && !r_wr) ? w_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance a uses LATENCY=4, instance b LATENCY=1.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_valid = 1'b0, a_wr = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0;
  logic        a_ready, a_rvalid, a_last, a_busy;
  logic [15:0] a_rdata;

  logic        b_valid = 1'b0, b_wr = 1'b0;
  logic [15:0] b_addr = '0, b_wdata = '0;
  logic        b_ready, b_rvalid, b_last, b_busy;
  logic [15:0] b_rdata;

`ifdef MEMRESP_BURST_EN
  logic a_burst = 1'b0, b_burst = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cnt;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(12), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_wr(a_wr),
    .req_addr(a_addr), .req_wdata(a_wdata),
`ifdef MEMRESP_BURST_EN
    .req_burst(a_burst),
`endif
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_last(a_last), .busy(a_busy)
  );

  mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(12), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_wr(b_wr),
    .req_addr(b_addr), .req_wdata(b_wdata),
`ifdef MEMRESP_BURST_EN
    .req_burst(b_burst),
`endif
    .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_last(b_last), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; afterwards the bench sits in cycle 0.
  task automatic issue(input bit sel, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, input bit burst);
    if (!sel) begin
      a_valid = 1'b1; a_wr = wr; a_addr = addr; a_wdata = data;
`ifdef MEMRESP_BURST_EN
      a_burst = burst;
`endif
    end else begin
      b_valid = 1'b1; b_wr = wr; b_addr = addr; b_wdata = data;
`ifdef MEMRESP_BURST_EN
      b_burst = burst;
`endif
    end
    tick(1);
    a_valid = 1'b0;
    b_valid = 1'b0;
`ifdef MEMRESP_BURST_EN
    a_burst = 1'b0;
    b_burst = 1'b0;
`else
    if (burst) a_wr = wr;
`endif
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_rvalid", a_rvalid, 1'b0);
    chk("rst_rdata", a_rdata, 16'h0000);
    chk("rst_last", a_last, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", a_ready, 1'b1);
    chk("post_rst_ready_b", b_ready, 1'b1);
    tick(1);

    // Store 0x1234 to 0x0010
    issue(0, 1'b1, 16'h0010, 16'h1234, 1'b0);
    chk("st_busy_c0", a_busy, 1'b1);
    chk("st_ready_c0", a_ready, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      chk("st_rvalid_early", a_rvalid, 1'b0);
    end
    tick(1);
    chk("st_rvalid_c4", a_rvalid, 1'b1);
    chk("st_last_c4", a_last, 1'b1);
    chk("st_rdata_c4", a_rdata, 16'h0000);
    tick(1);
    chk("st_ready_c5", a_ready, 1'b1);
    chk("st_rvalid_c5", a_rvalid, 1'b0);

    // Read-after-write
    issue(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
    tick(4);
    chk("ld_rvalid_c4", a_rvalid, 1'b1);
    chk("ld_rdata_c4", a_rdata, 16'h1234);
    chk("ld_last_c4", a_last, 1'b1);
    tick(1);
    chk("ld_ready_c5", a_ready, 1'b1);

    // Request held while busy
    issue(0, 1'b1, 16'h0002, 16'h5A5A, 1'b0);
    tick(5);
    a_valid = 1'b1; a_wr = 1'b0; a_addr = 16'h0002;
    tick(1);
    chk("hold_busy_c0", a_busy, 1'b1);
    tick(3);
    chk("hold_ready_c3", a_ready, 1'b0);
    tick(1);
    chk("hold_rvalid_c4", a_rvalid, 1'b1);
    chk("hold_rdata_c4", a_rdata, 16'h5A5A);
    tick(1);
    chk("hold_ready_c5", a_ready, 1'b1);
    chk("hold_rvalid_c5", a_rvalid, 1'b0);
    tick(1);
    chk("hold_reaccept_c6", a_busy, 1'b1);
    a_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (a_rvalid) cnt++;
    end
    chk("hold_one_resp", cnt, 1);

    // Reset in the middle of a store
    issue(0, 1'b1, 16'h0020, 16'h00C3, 1'b0);
    tick(5);
    issue(0, 1'b1, 16'h0020, 16'hDEAD, 1'b0);
    tick(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_ready", a_ready, 1'b0);
    tick(1);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (a_rvalid) cnt++;
    end
    chk("mid_rst_no_resp", cnt, 0);
    issue(0, 1'b0, 16'h0020, 16'h0000, 1'b0);
    tick(4);
    chk("mid_rst_old_data", a_rdata, 16'h00C3);
    tick(1);

`ifdef MEMRESP_BURST_EN
    // Burst line fill from words 8..11
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b1, 16'h0010 + 16'(2 * i), 16'h00A0 + 16'(i), 1'b0);
      tick(5);
    end
    issue(0, 1'b0, 16'h0014, 16'h0000, 1'b1);
    tick(3);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("burst_rvalid", a_rvalid, 1'b1);
      chk("burst_rdata", a_rdata, 16'h00A0 + 16'(i));
      chk("burst_last", a_last, (i == 3));
    end
    tick(1);
    chk("burst_busy_c8", a_busy, 1'b0);
    // Burst flag on a store is a plain single store
    issue(0, 1'b1, 16'h0016, 16'h0077, 1'b1);
    tick(4);
    chk("burst_wr_last", a_last, 1'b1);
    tick(1);
    chk("burst_wr_ready", a_ready, 1'b1);
`endif

    // LATENCY=1 with address wrap
    issue(1, 1'b1, 16'h0002, 16'h7E57, 1'b0);
    chk("l1_st_rvalid_c0", b_rvalid, 1'b0);
    tick(1);
    chk("l1_st_rvalid_c1", b_rvalid, 1'b1);
    tick(1);
    chk("l1_st_ready_c2", b_ready, 1'b1);
    issue(1, 1'b0, 16'h8002, 16'h0000, 1'b0);
    tick(1);
    chk("l1_ld_rvalid_c1", b_rvalid, 1'b1);
    chk("l1_ld_rdata_c1", b_rdata, 16'h7E57);
    chk("l1_ld_last_c1", b_last, 1'b1);
    tick(1);
    chk("l1_ld_ready_c2", b_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
